// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, control-bit indices and MEM-stage access FSM states
package mips_pkg;
    localparam int WORD_W = 32;
    localparam int REG_W = 5;
    localparam int WB_W = 2;
    localparam int M_W = 3;
    localparam int CTL_REGWRITE = 1;
    localparam int CTL_MEMTOREG = 0;
    localparam int CTL_BRANCH = 2;
    localparam int CTL_MEMREAD = 1;
    localparam int CTL_MEMWRITE = 0;
    typedef enum logic {IDLE, BUSY} mem_state_e;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs and MEM-stage outputs toward MEM/WB, IF and the hazard unit
interface mem_stage_if;
    import mips_pkg::*;
    logic [WB_W-1:0] control_wb_in;
    logic [M_W-1:0] control_m_in;
    logic [WORD_W-1:0] add_result_in;
    logic zero_in;
    logic [WORD_W-1:0] ALU_result_in;
    logic [WORD_W-1:0] rdata2_in;
    logic [REG_W-1:0] Write_reg_in;
    logic [WB_W-1:0] control_wb;
    logic [WORD_W-1:0] Read_data;
    logic [WORD_W-1:0] ALU_result;
    logic [REG_W-1:0] Write_reg;
    logic PCSrc;
    logic [WORD_W-1:0] branch_target;
    logic mem_stall;
    modport slave (
        input control_wb_in, control_m_in, add_result_in, zero_in, ALU_result_in, rdata2_in, Write_reg_in,
        output control_wb, Read_data, ALU_result, Write_reg, PCSrc, branch_target, mem_stall
    );
    modport master (
        output control_wb_in, control_m_in, add_result_in, zero_in, ALU_result_in, rdata2_in, Write_reg_in,
        input control_wb, Read_data, ALU_result, Write_reg, PCSrc, branch_target, mem_stall
    );
endinterface

// File: rtl/mem_stage_data_memory.sv
// data_memory: DEPTH x 32 word array, synchronous write, combinational read, no reset
module data_memory
    import mips_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int ADDR_W = 8
) (
    input logic clk,
    input logic we,
    input logic [ADDR_W-1:0] addr,
    input logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
    assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage (EX/MEM latch, data memory, PCSrc); MEM_WAIT_STATES_EN enables wait-state stalls
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int ADDR_W = 8,
    parameter int WAIT_STATES = 2
) (
    input logic clk,
    input logic rst,
    mem_stage_if.slave bus
);
    logic [WB_W-1:0] wb_q;
    logic [M_W-1:0] m_q;
    logic [WORD_W-1:0] add_q, alu_q, rd2_q, rdata;
    logic zero_q;
    logic [REG_W-1:0] wr_q;
    logic stall, access, we;
    always_ff @(posedge clk)
        if (rst) {wb_q, m_q, add_q, zero_q, alu_q, rd2_q, wr_q} <= '0;
        else if (!stall)
            {wb_q, m_q, add_q, zero_q, alu_q, rd2_q, wr_q} <= {bus.control_wb_in, bus.control_m_in,
                bus.add_result_in, bus.zero_in, bus.ALU_result_in, bus.rdata2_in, bus.Write_reg_in};
    assign access = m_q[CTL_MEMREAD] | m_q[CTL_MEMWRITE];
`ifdef MEM_WAIT_STATES_EN
    mem_state_e state, state_nx;
    logic [3:0] cnt, cnt_nx;
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
        end
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        stall = 1'b0;
        if (state == IDLE) begin
            if (access && WAIT_STATES > 0) begin
                stall = 1'b1;
                cnt_nx = 4'(WAIT_STATES - 1);
                state_nx = BUSY;
            end
        end else if (cnt != 4'd0) begin
            stall = 1'b1;
            cnt_nx = cnt - 4'd1;
        end else
            state_nx = IDLE;
    end
`else
    assign stall = 1'b0;
`endif
    // a store caught by reset in its completion cycle is dropped
    assign we = m_q[CTL_MEMWRITE] & ~stall & ~rst;
    data_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk(clk),
        .we(we),
        .addr(alu_q[ADDR_W+1:2]),
        .wdata(rd2_q),
        .rdata(rdata)
    );
    assign bus.control_wb = stall ? '0 : wb_q;
    assign bus.Read_data = (m_q[CTL_MEMREAD] & ~m_q[CTL_MEMWRITE] & ~stall) ? rdata : '0;
    assign bus.ALU_result = alu_q;
    assign bus.Write_reg = wr_q;
    assign bus.PCSrc = m_q[CTL_BRANCH] & zero_q;
    assign bus.branch_target = add_q;
    assign bus.mem_stall = stall;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage against a word-array reference model
module tb_mem_stage;
    localparam int WS = 2;
`ifdef MEM_WAIT_STATES_EN
    localparam int EFF_WS = WS;
`else
    localparam int EFF_WS = 0;
`endif
    typedef struct {
        logic [1:0] wb;
        logic [2:0] m;
        logic [31:0] add;
        logic zero;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0] wr;
    } instr_t;
    typedef struct {
        logic [1:0] wb;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0] wr;
        logic pcsrc;
        logic [31:0] tgt;
        int stalls;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    exp_t sb[$];
    exp_t e_mon;
    logic [31:0] mdl [256];
    int n_chk = 0;
    int n_fail = 0;
    int stall_run = 0;

    mem_stage_if bus();
    mem_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(WS)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic [2:0] m, input logic [31:0] alu, input logic [31:0] rd2,
                                  input logic [1:0] wb, input logic [4:0] wr, input logic [31:0] add,
                                  input logic zero);
        instr_t i;
        i.m = m; i.alu = alu; i.rd2 = rd2; i.wb = wb; i.wr = wr; i.add = add; i.zero = zero;
        return i;
    endfunction

    function automatic instr_t rnd_instr();
        return mk(3'($urandom_range(0, 7)), $urandom(), $urandom(), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 31)), $urandom(), 1'($urandom_range(0, 1)));
    endfunction

    // reference: memory is a plain array indexed by (byte address / 4) mod 256
    function automatic exp_t model(input instr_t i, input bit commit);
        exp_t e;
        int a = int'((i.alu / 4) % 256);
        e.wb = i.wb; e.alu = i.alu; e.wr = i.wr; e.tgt = i.add;
        e.pcsrc = i.m[2] & i.zero;
        e.rd = 32'h0;
        if (i.m[0]) begin
            if (commit) mdl[a] = i.rd2;
        end else if (i.m[1]) e.rd = mdl[a];
        e.stalls = (i.m[1] | i.m[0]) ? EFF_WS : 0;
        return e;
    endfunction

    task automatic drive(input instr_t i);
        bus.control_wb_in = i.wb;
        bus.control_m_in = i.m;
        bus.add_result_in = i.add;
        bus.zero_in = i.zero;
        bus.ALU_result_in = i.alu;
        bus.rdata2_in = i.rd2;
        bus.Write_reg_in = i.wr;
    endtask

    // called at a negedge; returns at the negedge after the instruction is latched
    task automatic issue(input instr_t i, input bit commit = 1'b1);
        int guard = 0;
        while (bus.mem_stall) begin
            drive(rnd_instr());
            @(negedge clk);
            guard++;
            if (guard > 40) begin
                n_fail++;
                $display("FAIL stall_timeout: mem_stall still %b after %0d cycles", bus.mem_stall, guard);
                $fatal(1, "stall never released");
            end
        end
        drive(i);
        @(posedge clk);
        sb.push_back(model(i, commit));
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            drive(rnd_instr());
            @(negedge clk);
        end
        sb.delete();
        rst = 1'b0;
        drive(mk(3'b000, 32'h0, 32'h0, 2'b00, 5'd0, 32'h0, 1'b0));
    endtask

    always @(negedge clk) begin
        if (rst_q) begin
            stall_run = 0;
            chk("rst_control_wb", 32'(bus.control_wb), 32'h0);
            chk("rst_Read_data", bus.Read_data, 32'h0);
            chk("rst_ALU_result", bus.ALU_result, 32'h0);
            chk("rst_Write_reg", 32'(bus.Write_reg), 32'h0);
            chk("rst_PCSrc", 32'(bus.PCSrc), 32'h0);
            chk("rst_branch_target", bus.branch_target, 32'h0);
            chk("rst_mem_stall", 32'(bus.mem_stall), 32'h0);
        end else if (bus.mem_stall) begin
            stall_run++;
            chk("stall_bubble_wb", 32'(bus.control_wb), 32'h0);
        end else if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            chk("control_wb", 32'(bus.control_wb), 32'(e_mon.wb));
            chk("Read_data", bus.Read_data, e_mon.rd);
            chk("ALU_result", bus.ALU_result, e_mon.alu);
            chk("Write_reg", 32'(bus.Write_reg), 32'(e_mon.wr));
            chk("PCSrc", 32'(bus.PCSrc), 32'(e_mon.pcsrc));
            chk("branch_target", bus.branch_target, e_mon.tgt);
            chk("stall_cycles", 32'(stall_run), 32'(e_mon.stalls));
            stall_run = 0;
        end else
            stall_run = 0;
    end

    initial begin
        int guard;
        drive(mk(3'b000, 32'h0, 32'h0, 2'b00, 5'd0, 32'h0, 1'b0));
        @(negedge clk);
        do_reset(2);
        for (int i = 0; i < 256; i++)
            issue(mk(3'b001, ($urandom() & 32'hFFFF_FC03) | (32'(i) << 2), $urandom(), 2'b00, 5'd0, $urandom(), 1'b0));
        issue(mk(3'b001, 32'h10, 32'hFF00AAD0, 2'b00, 5'd0, 32'h0, 1'b0));
        issue(mk(3'b010, 32'h10, 32'h0, 2'b11, 5'd3, 32'h0, 1'b0));
        issue(mk(3'b001, 32'h20, 32'h00ADAD10, 2'b00, 5'd0, 32'h0, 1'b0));
        issue(mk(3'b010, 32'h20, 32'h0, 2'b11, 5'd7, 32'h0, 1'b0));
        issue(mk(3'b100, 32'h5, 32'h0, 2'b00, 5'd0, 32'h40, 1'b1));
        issue(mk(3'b100, 32'h5, 32'h0, 2'b00, 5'd0, 32'h44, 1'b0));
        issue(mk(3'b001, 32'h403, 32'hDEADBEEF, 2'b00, 5'd0, 32'h0, 1'b0));
        issue(mk(3'b010, 32'h000, 32'h0, 2'b10, 5'd9, 32'h0, 1'b0));
        repeat (200) issue(rnd_instr());
        issue(mk(3'b001, 32'h30, 32'hA5A50030, 2'b00, 5'd0, 32'h0, 1'b0));
        issue(mk(3'b001, 32'h30, 32'h12345678, 2'b00, 5'd0, 32'h0, 1'b0), 1'b0);
        if (EFF_WS > 0) begin
            drive(rnd_instr());
            @(negedge clk);
        end
        do_reset(2);
        issue(mk(3'b010, 32'h30, 32'h0, 2'b11, 5'd4, 32'h0, 1'b0));
        issue(mk(3'b010, 32'h0, 32'h0, 2'b01, 5'd1, 32'h0, 1'b0));
        drive(mk(3'b000, 32'h0, 32'h0, 2'b00, 5'd0, 32'h0, 1'b0));
        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEMORY stage of the 5-stage MIPS pipeline: EX/MEM pipeline latch, word-addressed data memory, and branch resolution (PCSrc).
- Sits between the EX stage and the MEM/WB latch, and feeds control_wb, Read_data, ALU_result and Write_reg directly into MEM/WB.
- Supports a configurable number of memory wait states and stalls the pipeline while an access is in flight.

Parameters:
- DEPTH, 256: data memory size in 32-bit words; power of 2.
- ADDR_W, 8: word-address width, equal to log2(DEPTH).
- WAIT_STATES, 2: stall cycles per load/store, range 0..15. Used only when MEM_WAIT_STATES_EN is defined.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous active-high reset.
- control_wb_in  in  2  {RegWrite, MemtoReg} from EX.
- control_m_in  in  3  {Branch, MemRead, MemWrite} from EX.
- add_result_in  in  32  branch target from EX.
- zero_in  in  1  ALU zero flag.
- ALU_result_in  in  32  ALU result / byte address.
- rdata2_in  in  32  store data.
- Write_reg_in  in  5  destination register.
- control_wb  out  2  to MEM/WB.
- Read_data  out  32  load data to MEM/WB.
- ALU_result  out  32  latched ALU result to MEM/WB.
- Write_reg  out  5  latched destination to MEM/WB.
- PCSrc  out  1  branch taken, to IF.
- branch_target  out  32  latched add_result, to IF.
- mem_stall  out  1  high while a memory access is incomplete; the hazard unit freezes IF, ID, EX and the PC.

Behaviour:
- EX/MEM latch:
  - Captures all *_in inputs on posedge clk when mem_stall=0.
  - Holds its value when mem_stall=1.
  - rst clears every latch field to 0.
- Outputs:
  - ALU_result, Write_reg and branch_target come straight from the latch.
  - PCSrc = latched Branch & latched zero. It is independent of the stall, because a branch never accesses memory.
  - control_wb = latched control_wb when mem_stall=0, otherwise 2'b00. This inserts a bubble into MEM/WB during a stall.
- Addressing:
  - Word address = latched ALU_result[ADDR_W+1:2].
  - ALU_result[1:0] is ignored (no alignment trap).
  - Upper bits are ignored, so addresses wrap modulo DEPTH.
- Access FSM, states IDLE and BUSY, counter cnt (4 bits):
  - IDLE, latched MemRead|MemWrite, WAIT_STATES>0: mem_stall=1, cnt<=WAIT_STATES-1, next state BUSY.
  - BUSY, cnt!=0: mem_stall=1, cnt<=cnt-1.
  - BUSY, cnt==0: mem_stall=0; the access completes this cycle; next state IDLE.
  - Net effect: mem_stall is high for exactly WAIT_STATES cycles per access, and the access completes on the following cycle.
  - When WAIT_STATES=0 the FSM never leaves IDLE and every access completes in its own cycle.
  - Back-to-back accesses: the next access enters the latch on the completion edge, and its stall begins immediately.
- Memory write: occurs on posedge clk in the completion cycle only, when MemWrite=1 and mem_stall=0. Each store writes exactly once.
- Memory read:
  - Read_data = mem[addr] combinationally when MemRead=1 and mem_stall=0; otherwise 32'h0.
  - Read data reflects all stores completed earlier.
- MemRead and MemWrite both set: the write is performed and Read_data = 0.
- rst mid-access:
  - FSM goes to IDLE, cnt=0, mem_stall=0 and the latch clears.
  - An in-flight store is dropped.
  - Memory contents are preserved; the array has no reset.
- Reset values: control_wb=0, Read_data=0, ALU_result=0, Write_reg=0, PCSrc=0, branch_target=0, mem_stall=0.

Optional Feature:
- Macro: MEM_WAIT_STATES_EN.
- Defined: the FSM, counter and WAIT_STATES behave as described above.
- Not defined: no FSM or counter is generated; mem_stall is tied to 0 and every load/store completes in the cycle it is latched. The WAIT_STATES parameter is ignored.

Decomposition:
- Package mips_pkg:
  - Control-bit index constants: CTL_REGWRITE=1, CTL_MEMTOREG=0, CTL_BRANCH=2, CTL_MEMREAD=1, CTL_MEMWRITE=0.
  - Widths: WORD_W=32, REG_W=5, WB_W=2, M_W=3.
  - Enum for the FSM states.
- Sub-module data_memory: DEPTH x 32 array, synchronous write with a write-enable, combinational read.
- The latch, FSM and PCSrc logic stay in mem_stage.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> all outputs 0, mem_stall=0.
- Store then load, WAIT_STATES=0:
  - Stimulus: sw with ALU_result=0x10, rdata2=0xFF00AAD0, then lw at 0x10, control_wb_in=2'b11, Write_reg_in=3.
  - Required: Read_data=0xFF00AAD0, control_wb=2'b11, Write_reg=3, mem_stall never high.
- Wait states, WAIT_STATES=2, lw at 0x20 holding 0x00ADAD10:
  - mem_stall high exactly 2 cycles, with control_wb=00 during the stall.
  - Third cycle: Read_data=0x00ADAD10, control_wb restored.
  - EX inputs changed during the stall are not captured.
- Branch: Branch=1, zero_in=1, add_result_in=0x40 -> PCSrc=1 and branch_target=0x40 one cycle later. With zero_in=0 -> PCSrc=0.
- Wrap and alignment, DEPTH=256: sw 0xDEADBEEF to ALU_result=0x403 -> lw at 0x000 returns 0xDEADBEEF.
- Reset mid-access: sw 0x12345678 to 0x30 with WAIT_STATES=3, rst asserted after 1 stall cycle -> mem_stall=0 next cycle; a later lw at 0x30 returns the prior contents.
